// File: rtl/imgmem_rect_writer.sv
// Rectangle-fill write master for the 640x480 8-bit palette-index image memory.
// Optional power-up clear of the whole frame: define IMGMEM_WRITER_CLEAR_EN.
module imgmem_rect_writer #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter logic [7:0]  CLR_IDX = 8'h00
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iREQ_valid,
  output logic        oREQ_ready,
  input  logic [9:0]  iX,
  input  logic [8:0]  iY,
  input  logic [9:0]  iW,
  input  logic [8:0]  iH,
  input  logic [7:0]  iCOLOR,
  output logic        oWE,
  output logic [18:0] oADDR,
  output logic [7:0]  oDATA,
  output logic        oDONE
);

  localparam logic [9:0]  HRES_W = 10'(H_RES);
  localparam logic [8:0]  VRES_W = 9'(V_RES);
  localparam logic [18:0] ROW_STEP = 19'(H_RES);
  localparam logic [18:0] LAST_PIX = 19'(H_RES * V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
`ifdef IMGMEM_WRITER_CLEAR_EN
    S_CLEAR,
`endif
    S_DONE
  } state_t;

  state_t      state_q;
  logic [9:0]  x_q, w_q, ew_q, col_q;
  logic [8:0]  y_q, h_q, eh_q, row_q;
  logic [7:0]  c_q;
  logic [18:0] base_q, addr_q;
  logic        ready_q, we_q, done_q;
  logic [18:0] oaddr_q;
  logic [7:0]  odata_q;

  logic [9:0]  ew_d;
  logic [8:0]  eh_d;
  logic [18:0] base_d;
  logic        clearing;

`ifdef IMGMEM_WRITER_CLEAR_EN
  assign clearing = (state_q == S_CLEAR);
`else
  assign clearing = 1'b0;
`endif

  // Clip against the frame edge; origin outside the frame yields an empty rectangle.
  always_comb begin
    ew_d   = '0;
    eh_d   = '0;
    base_d = 19'({y_q, 9'b0}) + 19'({y_q, 7'b0}) + 19'(x_q);
    if (x_q < HRES_W && y_q < VRES_W) begin
      ew_d = (w_q < HRES_W - x_q) ? w_q : HRES_W - x_q;
      eh_d = (h_q < VRES_W - y_q) ? h_q : VRES_W - y_q;
    end
  end

  // Outputs are registered from the current state, so the memory port lags
  // the address counter by one cycle.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
`ifdef IMGMEM_WRITER_CLEAR_EN
      state_q <= S_CLEAR;
      ready_q <= 1'b0;
`else
      state_q <= S_IDLE;
      ready_q <= 1'b1;
`endif
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      ew_q    <= '0;
      eh_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      we_q   <= (state_q == S_WRITE) || clearing;
      done_q <= (state_q == S_DONE);
      if ((state_q == S_WRITE) || clearing) begin
        oaddr_q <= addr_q;
        odata_q <= clearing ? CLR_IDX : c_q;
      end
      case (state_q)
        S_IDLE: begin
          if (iREQ_valid) begin
            x_q     <= iX;
            y_q     <= iY;
            w_q     <= iW;
            h_q     <= iH;
            c_q     <= iCOLOR;
            ready_q <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          ew_q    <= ew_d;
          eh_q    <= eh_d;
          base_q  <= base_d;
          addr_q  <= base_d;
          col_q   <= '0;
          row_q   <= '0;
          state_q <= (ew_d == '0 || eh_d == '0) ? S_DONE : S_WRITE;
        end
        S_WRITE: begin
          if (col_q == ew_q - 10'd1) begin
            col_q <= '0;
            if (row_q == eh_q - 9'd1) begin
              state_q <= S_DONE;
            end else begin
              row_q  <= row_q + 9'd1;
              base_q <= base_q + ROW_STEP;
              addr_q <= base_q + ROW_STEP;
            end
          end else begin
            col_q  <= col_q + 10'd1;
            addr_q <= addr_q + 19'd1;
          end
        end
`ifdef IMGMEM_WRITER_CLEAR_EN
        S_CLEAR: begin
          if (addr_q == LAST_PIX) state_q <= S_DONE;
          else                    addr_q  <= addr_q + 19'd1;
        end
`endif
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oREQ_ready = ready_q;
  assign oWE        = we_q;
  assign oADDR      = oaddr_q;
  assign oDATA      = odata_q;
  assign oDONE      = done_q;

endmodule

// File: tb/tb_imgmem_rect_writer.sv
// Scoreboard bench for imgmem_rect_writer: stimulus pushes expected writes/done
// events, a negedge monitor pops and compares whatever the DUT presents.
module tb_imgmem_rect_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  x = '0, w = '0;
  logic [8:0]  y = '0, h = '0;
  logic [7:0]  c = '0;
  logic        ready, we, done;
  logic [18:0] addr;
  logic [7:0]  data;

  imgmem_rect_writer dut (
    .iCLK(clk), .iRST_n(rst_n), .iREQ_valid(valid), .oREQ_ready(ready),
    .iX(x), .iY(y), .iW(w), .iH(h), .iCOLOR(c),
    .oWE(we), .oADDR(addr), .oDATA(data), .oDONE(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [18:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t sbq[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic exp_wr(input logic [18:0] a, input logic [7:0] d);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0;
    sbq.push_back(e);
  endtask

  // Monitor: each presented write or done pulse must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (we) begin
        if (sbq.size() == 0) check("unexpected_write_addr", addr, -1);
        else begin
          e = sbq.pop_front();
          check("wr_kind", e.is_done, 0);
          check("wr_addr", addr, e.addr);
          check("wr_data", data, e.data);
        end
      end
      if (done) begin
        if (sbq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          check("done_kind", e.is_done, 1);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", ready, 1);
  endtask

  // Issue one request and check the write burst length and done timing.
  task automatic run_req(input logic [9:0] rx, input logic [8:0] ry, input logic [9:0] rw,
                         input logic [8:0] rh, input logic [7:0] rc, input int n,
                         input bit junk);
    int cnt = 0;
    exp_done();
    wait_ready();
    x = rx; y = ry; w = rw; h = rh; c = rc; valid = 1'b1;
    @(posedge clk);
    #1;
    if (junk) begin
      x = 10'd1; y = 9'd1; w = 10'd9; h = 9'd9; c = 8'hFF;
    end else begin
      valid = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    while (we && cnt < n + 10) begin
      cnt++;
      @(negedge clk);
    end
    check("write_count", cnt, n);
    check("done_after_writes", done, 1);
    check("ready_with_done", ready, 1);
  endtask

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    repeat (3) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_done", done, 0);
`ifdef IMGMEM_WRITER_CLEAR_EN
    check("rst_ready", ready, 0);
    for (int i = 0; i < 307200; i++) exp_wr(19'(i), 8'h00);
    exp_done();
    rst_n = 1'b1;
    @(negedge clk);
    check("clear_ready_low", ready, 0);
    begin
      int k = 0;
      while (!ready && k < 310000) begin
        @(negedge clk);
        k++;
      end
    end
    check("clear_finished_ready", ready, 1);
    check("clear_queue_empty", sbq.size(), 0);
`else
    check("rst_ready", ready, 1);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (we || done || !ready) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);
`endif

    // 3x2 at (10,2); inputs scrambled and valid held while busy
    exp_wr(19'd1290, 8'h5A); exp_wr(19'd1291, 8'h5A); exp_wr(19'd1292, 8'h5A);
    exp_wr(19'd1930, 8'h5A); exp_wr(19'd1931, 8'h5A); exp_wr(19'd1932, 8'h5A);
    run_req(10'd10, 9'd2, 10'd3, 9'd2, 8'h5A, 6, 1'b1);

    // Bottom-right corner clip
    exp_wr(19'd307198, 8'h07); exp_wr(19'd307199, 8'h07);
    run_req(10'd638, 9'd479, 10'd5, 9'd5, 8'h07, 2, 1'b0);

    // Height clip at the bottom edge
    exp_wr(19'd305920, 8'hA1); exp_wr(19'd305921, 8'hA1);
    exp_wr(19'd306560, 8'hA1); exp_wr(19'd306561, 8'hA1);
    run_req(10'd0, 9'd478, 10'd2, 9'd5, 8'hA1, 4, 1'b0);

    // Empty rectangles
    run_req(10'd5, 9'd5, 10'd0, 9'd3, 8'h11, 0, 1'b0);
    run_req(10'd700, 9'd5, 10'd4, 9'd3, 8'h22, 0, 1'b0);
    run_req(10'd5, 9'd480, 10'd4, 9'd3, 8'h23, 0, 1'b0);

    // 4x4 at (20,10) with reset on the third write
    exp_wr(19'd6420, 8'h33); exp_wr(19'd6421, 8'h33);
    wait_ready();
    x = 10'd20; y = 9'd10; w = 10'd4; h = 9'd4; c = 8'h33; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_we_drop", we, 0);
    check("midrst_done_low", done, 0);
    check("midrst_addr", addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_queue_empty", sbq.size(), 0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (we || done || !ready) bad = 1'b1;
    end
    check("midrst_quiet", bad, 0);

    exp_wr(19'd0, 8'hC3);
    run_req(10'd0, 9'd0, 10'd1, 9'd1, 8'hC3, 1, 1'b0);

    repeat (5) @(negedge clk);
    check("final_queue_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
